// File: rtl/uart_rx_ctrl.sv
// Receive-control stage of the UART receiver.
// This stage synchronises the serial line and detects the start edge. It runs the
// IDLE/RECEIVE/STOP_CHK/LOAD control FSM that gates the downstream bit timer.
// It also owns the received-byte buffer and its ready/overrun/framing flags.
module uart_rx_ctrl #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 shift_enable,
  input  logic                 packet_done,
  input  logic [DATA_BITS-1:0] packet_data,
  input  logic                 stop_bit,
  input  logic                 data_read,
  output logic                 enable_timer,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECEIVE  = 2'd1,
    STOP_CHK = 2'd2,
    LOAD     = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic                 start_edge;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 data_ready_q, data_ready_d;
  logic                 overrun_q, overrun_d;
  logic                 framing_q, framing_d;

  // The bit timer generates its own sample strobes, so the control path never needs them.
  logic unused_shift_enable;
  assign unused_shift_enable = shift_enable;

  // A high-to-low transition of the synchronised line marks a candidate start bit.
  assign start_edge = prev_q & ~sync2_q;

  // Two-flop synchroniser plus previous-sample flop; all reset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // State register; reset aborts any packet in progress.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start edges outside IDLE are ignored, which gives glitch immunity mid-packet.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_edge)  state_d = RECEIVE;
      RECEIVE:  if (packet_done) state_d = STOP_CHK;
      STOP_CHK: state_d = stop_bit ? LOAD : IDLE;
      LOAD:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Moore timer enable plus next values of the buffer and flags.
  always_comb begin
    enable_timer = (state_q == RECEIVE);
    rx_data_d    = rx_data_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    framing_d    = framing_q;

    if (state_q == IDLE && start_edge)      framing_d = 1'b0;
    if (state_q == STOP_CHK && !stop_bit)   framing_d = 1'b1;

    if (state_q == LOAD) begin
      // A load beats a coincident host read: the new byte is unread and no overrun is flagged.
      rx_data_d    = packet_data;
      data_ready_d = 1'b1;
      if (data_ready_q && !data_read) overrun_d = 1'b1;
    end else if (data_read && data_ready_q) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  // Output buffer and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q    <= {DATA_BITS{1'b1}};
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      framing_q    <= 1'b0;
    end else begin
      rx_data_q    <= rx_data_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
      framing_q    <= framing_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign data_ready    = data_ready_q;
  assign overrun_error = overrun_q;
  assign framing_error = framing_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: the stimulus side plays the line and the bit timer.
// After each packet it pushes the expected buffer/flag state.
// A monitor pops one entry each time a packet completes (timer enable falls).
module tb_uart_rx_ctrl;

  localparam int SPAN = 90;

  typedef struct packed {
    logic [7:0] d;
    logic       rdy;
    logic       ovr;
    logic       fr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic       shift_enable = 1'b0;
  logic       packet_done = 1'b0;
  logic [7:0] packet_data = 8'h00;
  logic       stop_bit = 1'b1;
  logic       data_read = 1'b0;
  logic       enable_timer;
  logic [7:0] rx_data;
  logic       data_ready, overrun_error, framing_error;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  // Reference state of the receiver as seen by the host.
  logic [7:0] m_data = 8'hFF;
  logic       m_ready = 1'b0, m_ovr = 1'b0, m_fr = 1'b0;

  uart_rx_ctrl #(.DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .shift_enable(shift_enable),
    .packet_done(packet_done), .packet_data(packet_data), .stop_bit(stop_bit),
    .data_read(data_read), .enable_timer(enable_timer), .rx_data(rx_data),
    .data_ready(data_ready), .overrun_error(overrun_error), .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Send one packet: line falls, then the timer model counts SPAN enabled cycles and pulses packet_done.
  task automatic send_frame(input logic [7:0] d, input logic sb_bit, input logic rd_load);
    int cnt = 0;
    int w = 0;
    @(negedge clk);
    serial_in = 1'b0;
    while (!enable_timer && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("start_accept", {31'd0, enable_timer}, 32'd1);
    if (!enable_timer) begin
      serial_in = 1'b1;
      return;
    end
    check("fe_clear_on_start", {31'd0, framing_error}, 32'd0);
    m_fr = 1'b0;
    w = 0;
    while (1) begin
      if (enable_timer) cnt++;
      // Line wiggles randomly (including falls) mid-packet, then settles high for the stop bit.
      serial_in = (cnt < SPAN - 12) ? 1'($urandom) : 1'b1;
      if (cnt == SPAN) begin
        packet_done = 1'b1;
        packet_data = d;
        stop_bit    = sb_bit;
        break;
      end
      packet_data = 8'($urandom);
      stop_bit    = 1'($urandom);
      if (w > 300) break;
      @(negedge clk);
      w++;
    end
    check("timer_reached_span", cnt, SPAN);
    if (sb_bit) begin
      if (!rd_load) m_ovr = m_ovr | m_ready;
      m_ready = 1'b1;
      m_data  = d;
    end else begin
      m_fr = 1'b1;
    end
    sb.push_back('{d: m_data, rdy: m_ready, ovr: m_ovr, fr: m_fr});
    @(negedge clk);
    packet_done = 1'b0;
    @(negedge clk);
    if (rd_load) data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // One-cycle host read pulse, then compare the flags directly.
  task automatic host_read();
    @(negedge clk);
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
    if (m_ready) begin
      m_ready = 1'b0;
      m_ovr   = 1'b0;
    end
    check("read_ready", {31'd0, data_ready}, {31'd0, m_ready});
    check("read_ovr", {31'd0, overrun_error}, {31'd0, m_ovr});
    check("read_data", {24'd0, rx_data}, {24'd0, m_data});
  endtask

  // Start a packet and assert reset in the middle of RECEIVE.
  task automatic reset_mid_receive();
    int w = 0;
    @(negedge clk);
    serial_in = 1'b0;
    while (!enable_timer && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("rst_test_start", {31'd0, enable_timer}, 32'd1);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    serial_in = 1'b1;
    @(negedge clk);
    check("rst_enable", {31'd0, enable_timer}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'hFF);
    check("rst_ready", {31'd0, data_ready}, 32'd0);
    check("rst_ovr", {31'd0, overrun_error}, 32'd0);
    check("rst_fe", {31'd0, framing_error}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_data = 8'hFF; m_ready = 1'b0; m_ovr = 1'b0; m_fr = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_no_restart", {31'd0, enable_timer}, 32'd0);
  endtask

  // Monitor: a falling timer enable marks packet end; outputs settle two cycles later.
  initial begin
    logic en_prev = 1'b0;
    int   hi = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        en_prev = 1'b0;
        hi = 0;
      end else begin
        if (enable_timer) hi++;
        else if (en_prev) begin
          check("enable_span", hi, SPAN);
          hi = 0;
          repeat (2) @(negedge clk);
          check("sb_has_entry", {31'd0, (sb.size() != 0)}, 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("mon_rx_data", {24'd0, rx_data}, {24'd0, e.d});
            check("mon_ready", {31'd0, data_ready}, {31'd0, e.rdy});
            check("mon_ovr", {31'd0, overrun_error}, {31'd0, e.ovr});
            check("mon_fe", {31'd0, framing_error}, {31'd0, e.fr});
          end
        end
        en_prev = enable_timer;
      end
    end
  end

  initial begin
    int w = 0;
    logic st, rd;
    repeat (3) @(negedge clk);
    check("init_enable", {31'd0, enable_timer}, 32'd0);
    check("init_rx_data", {24'd0, rx_data}, 32'hFF);
    check("init_flags", {29'd0, data_ready, overrun_error, framing_error}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    send_frame(8'hA5, 1'b1, 1'b0);   // good frame
    send_frame(8'h3C, 1'b0, 1'b0);   // framing error, buffer untouched
    send_frame(8'h11, 1'b1, 1'b0);   // next start clears framing_error
    send_frame(8'h22, 1'b1, 1'b0);   // overrun
    host_read();
    send_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h66, 1'b1, 1'b0);   // overrun set again before reset
    send_frame(8'h77, 1'b0, 1'b0);   // framing set before reset
    reset_mid_receive();
    send_frame(8'h44, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1);   // read coincides with LOAD
    host_read();
    host_read();                     // read with nothing ready

    for (int i = 0; i < 20; i++) begin
      st = ($urandom_range(0, 4) != 0);
      rd = st & 1'($urandom);
      send_frame(8'($urandom), st, rd);
      if ($urandom_range(0, 2) == 0) host_read();
    end

    while (sb.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
